// File: rtl/pat_field_buffer.sv
// Pattern field buffer: a ring of field buffers shared by three parties.
// A fill stream loads EMPTY buffers. The pattern core reads and modifies
// the LOADED buffer at bufp. A drain stream empties DONE buffers.
// Each party only moves its own buffers forward, so the three can overlap.
module pat_field_buffer #(
    parameter int bufp_width   = 3,
    parameter int fieldp_width = 5,
    parameter int buffer_width = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    // core field interface
    input  logic [fieldp_width-1:0] fieldp,
    output logic [buffer_width-1:0] field_in,
    input  logic [fieldp_width-1:0] fieldwp,
    input  logic [buffer_width-1:0] field_out,
    input  logic                    field_write,
    input  logic                    buf_done,
    output logic [bufp_width-1:0]   bufp,
    output logic                    buf_valid,
    // fill stream
    input  logic [buffer_width-1:0] s_data,
    input  logic                    s_valid,
    input  logic                    s_last,
    output logic                    s_ready,
    // drain stream
    output logic [buffer_width-1:0] m_data,
    output logic                    m_valid,
    output logic                    m_last,
    input  logic                    m_ready
);

    localparam int NBUF   = 1 << bufp_width;
    localparam int NFIELD = 1 << fieldp_width;
    localparam logic [fieldp_width-1:0] LAST_FIELD = '1;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOADED = 2'd1,
        DONE   = 2'd2
    } buf_state_t;

    logic [buffer_width-1:0] mem [NBUF][NFIELD];
    buf_state_t              buf_state [NBUF];

    logic [bufp_width-1:0]   fill_ptr;
    logic [bufp_width-1:0]   drain_ptr;
    logic [fieldp_width-1:0] fill_idx;
    logic [fieldp_width-1:0] drain_idx;

    logic fill_fire;
    logic core_write;
    logic core_done;
    logic drain_fire;
    logic fill_end;

    // Handshake and status decode; each side looks only at its own buffer.
    always_comb begin
        s_ready    = (buf_state[fill_ptr] == EMPTY);
        buf_valid  = (buf_state[bufp] == LOADED);
        m_valid    = (buf_state[drain_ptr] == DONE);
        m_data     = mem[drain_ptr][drain_idx];
        m_last     = m_valid && (drain_idx == LAST_FIELD);
        fill_fire  = s_valid && s_ready;
        fill_end   = s_last || (fill_idx == LAST_FIELD);
        core_write = field_write && buf_valid;
        core_done  = buf_done && buf_valid;
        drain_fire = m_valid && m_ready;
    end

    // Field storage, not reset. Fill and core never target the same buffer
    // because one needs EMPTY and the other LOADED.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (fill_fire)
                mem[fill_ptr][fill_idx] <= s_data;
            if (core_write)
                mem[bufp][fieldwp] <= field_out;
        end
    end

    // Buffer states, ring pointers and the registered core read port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NBUF; i++)
                buf_state[i] <= EMPTY;
            fill_ptr  <= '0;
            bufp      <= '0;
            drain_ptr <= '0;
            fill_idx  <= '0;
            drain_idx <= '0;
            field_in  <= '0;
        end else begin
            // read-before-write: a same-cycle write shows up on the next read
            field_in <= mem[bufp][fieldp];

            if (fill_fire) begin
                if (fill_end) begin
                    buf_state[fill_ptr] <= LOADED;
                    fill_ptr            <= fill_ptr + 1'b1;
                    fill_idx            <= '0;
                end else begin
                    fill_idx <= fill_idx + 1'b1;
                end
            end

            if (core_done) begin
                buf_state[bufp] <= DONE;
                bufp            <= bufp + 1'b1;
            end

            if (drain_fire) begin
                if (m_last) begin
                    buf_state[drain_ptr] <= EMPTY;
                    drain_ptr            <= drain_ptr + 1'b1;
                    drain_idx            <= '0;
                end else begin
                    drain_idx <= drain_idx + 1'b1;
                end
            end
        end
    end

endmodule
